// File: rtl/result_uart_streamer_if.sv
// Bundles the output-BRAM read port and the byte stream toward uart_tx.
// The streamer is the master on both: it issues reads and presents bytes.
interface result_uart_streamer_if #(
  parameter int ADDR_W = 10
);
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [31:0]       rd_data;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (
    output rd_en, rd_addr, tx_data, tx_valid,
    input  rd_data, tx_ready
  );

  modport slave (
    input  rd_en, rd_addr, tx_data, tx_valid,
    output rd_data, tx_ready
  );
endinterface

// File: rtl/result_uart_streamer.sv
// Reads N result words from the output BRAM and streams them as a frame:
// SYNC, count (LE16), little-endian payload, 8-bit additive checksum.
module result_uart_streamer #(
  parameter int         ADDR_W    = 10,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_start,
  input  logic [ADDR_W:0]        i_cfg_count,
  result_uart_streamer_if.master m_bus,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [ADDR_W:0]        o_words_sent
);

  localparam int CW = ADDR_W + 1;
  localparam logic [CW-1:0]     MAX_N   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [CW-1:0]     CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] IDX_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
    S_FETCH = 3'd2,
    S_WAIT  = 3'd3,
    S_SEND  = 3'd4,
    S_CSUM  = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

  state_t            r_state;
  logic [CW-1:0]     r_n;
  logic [CW-1:0]     r_words_sent;
  logic [ADDR_W-1:0] r_idx;
  logic [1:0]        r_byte_cnt;
  logic [31:0]       r_shift;
  logic [7:0]        r_csum;
  logic [7:0]        r_tx_data;
  logic              r_tx_valid;
  logic              r_rd_en;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_busy;
  logic              r_done;

  logic              w_fire;
  logic [7:0]        w_csum_next;
  logic [15:0]       w_n16;
  logic [CW-1:0]     w_clamped;
  logic [CW-1:0]     w_sent_next;

  assign w_fire      = r_tx_valid && m_bus.tx_ready;
  assign w_csum_next = csum_add(r_csum, r_tx_data);
  assign w_n16       = {{(16-CW){1'b0}}, r_n};
  assign w_sent_next = r_words_sent + CNT_ONE;

  // Clamp the requested word count to the BRAM depth.
  always_comb begin
    w_clamped = i_cfg_count;
    if (i_cfg_count > MAX_N) begin
      w_clamped = MAX_N;
    end else begin
      w_clamped = i_cfg_count;
    end
  end

  // Frame sequencer; every output is driven straight from a register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_n          <= '0;
      r_words_sent <= '0;
      r_idx        <= '0;
      r_byte_cnt   <= 2'd0;
      r_shift      <= 32'h0000_0000;
      r_csum       <= 8'h00;
      r_tx_data    <= 8'h00;
      r_tx_valid   <= 1'b0;
      r_rd_en      <= 1'b0;
      r_rd_addr    <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_n          <= w_clamped;
            r_csum       <= 8'h00;
            r_words_sent <= '0;
            r_idx        <= '0;
            r_byte_cnt   <= 2'd0;
            r_busy       <= 1'b1;
            r_tx_valid   <= 1'b1;
            r_tx_data    <= SYNC_BYTE;
            r_state      <= S_HDR;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_HDR: begin
          if (w_fire) begin
            // The sync byte is excluded from the checksum.
            if (r_byte_cnt != 2'd0) begin
              r_csum <= w_csum_next;
            end else begin
              r_csum <= r_csum;
            end
            case (r_byte_cnt)
              2'd0: begin
                r_tx_data  <= w_n16[7:0];
                r_byte_cnt <= 2'd1;
              end
              2'd1: begin
                r_tx_data  <= w_n16[15:8];
                r_byte_cnt <= 2'd2;
              end
              default: begin
                r_byte_cnt <= 2'd0;
                if (r_n == '0) begin
                  r_tx_data <= w_csum_next;
                  r_state   <= S_CSUM;
                end else begin
                  r_tx_valid <= 1'b0;
                  r_rd_en    <= 1'b1;
                  r_rd_addr  <= '0;
                  r_state    <= S_FETCH;
                end
              end
            endcase
          end else begin
            r_state <= S_HDR;
          end
        end
        S_FETCH: begin
          r_rd_en <= 1'b0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_shift    <= m_bus.rd_data;
          r_tx_data  <= m_bus.rd_data[7:0];
          r_tx_valid <= 1'b1;
          r_byte_cnt <= 2'd0;
          r_state    <= S_SEND;
        end
        S_SEND: begin
          if (w_fire) begin
            r_csum <= w_csum_next;
            if (r_byte_cnt != 2'd3) begin
              r_shift    <= {8'h00, r_shift[31:8]};
              r_tx_data  <= r_shift[15:8];
              r_byte_cnt <= r_byte_cnt + 2'd1;
            end else begin
              r_byte_cnt   <= 2'd0;
              r_words_sent <= w_sent_next;
              if (w_sent_next == r_n) begin
                r_tx_data <= w_csum_next;
                r_state   <= S_CSUM;
              end else begin
                r_tx_valid <= 1'b0;
                r_idx      <= r_idx + IDX_ONE;
                r_rd_addr  <= r_idx + IDX_ONE;
                r_rd_en    <= 1'b1;
                r_state    <= S_FETCH;
              end
            end
          end else begin
            r_state <= S_SEND;
          end
        end
        S_CSUM: begin
          if (w_fire) begin
            r_tx_valid <= 1'b0;
            r_done     <= 1'b1;
            r_busy     <= 1'b0;
            r_state    <= S_DONE;
          end else begin
            r_state <= S_CSUM;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_tx_valid <= 1'b0;
          r_rd_en    <= 1'b0;
          r_busy     <= 1'b0;
          r_done     <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

  assign m_bus.rd_en    = r_rd_en;
  assign m_bus.rd_addr  = r_rd_addr;
  assign m_bus.tx_data  = r_tx_data;
  assign m_bus.tx_valid = r_tx_valid;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_words_sent   = r_words_sent;

endmodule

// File: tb/tb_result_uart_streamer.sv
// Self-checking bench: table of frames checked against a queue-based frame
// model, plus literal-byte frames, a mid-frame start and a mid-frame reset.
module tb_result_uart_streamer;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [ADDR_W:0]   cfg_count;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   words_sent;

  result_uart_streamer_if #(.ADDR_W(ADDR_W)) bus ();

  result_uart_streamer #(.ADDR_W(ADDR_W), .SYNC_BYTE(8'hA5)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_start      (start),
    .i_cfg_count  (cfg_count),
    .m_bus        (bus),
    .o_busy       (busy),
    .o_done       (done),
    .o_words_sent (words_sent)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:1023];
  int          ready_pct = 100;
  int          errors = 0;
  int          checks = 0;

  // Synchronous-read BRAM: data valid the cycle after rd_en.
  always @(posedge clk) begin
    if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
  end

  always @(negedge clk) bus.tx_ready = ($urandom_range(0, 99) < ready_pct);

  logic [7:0] cap_q[$];
  int         addr_q[$];
  int         done_cnt = 0;
  int         stall_err = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  // Monitor: capture transferred bytes, read addresses, done pulses, stall holds.
  always @(posedge clk) begin
    if (!rst_n) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall && (!bus.tx_valid || bus.tx_data !== prev_data)) stall_err <= stall_err + 1;
      prev_stall <= bus.tx_valid && !bus.tx_ready;
      prev_data  <= bus.tx_data;
      if (bus.tx_valid && bus.tx_ready) cap_q.push_back(bus.tx_data);
      if (bus.rd_en) addr_q.push_back(int'(bus.rd_addr));
      if (done) done_cnt <= done_cnt + 1;
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  logic [7:0] exp_q[$];

  // Reference frame built directly from the framing rules.
  task automatic model(input int cfg);
    int         n;
    logic [7:0] sum;
    logic [7:0] b;
    n = (cfg > 1024) ? 1024 : cfg;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'(n % 256));
    exp_q.push_back(8'(n / 256));
    sum = 8'(n % 256) + 8'(n / 256);
    for (int w = 0; w < n; w++) begin
      for (int k = 0; k < 4; k++) begin
        b = 8'(mem[w] >> (8 * k));
        exp_q.push_back(b);
        sum = sum + b;
      end
    end
    exp_q.push_back(sum);
  endtask

  task automatic run_frame(input int cfg, input int pct, input bit mid_start);
    int n, d0, s0, drop, cyc, mism;
    bit timed_out;
    n = (cfg > 1024) ? 1024 : cfg;
    ready_pct = pct;
    cap_q.delete();
    addr_q.delete();
    d0 = done_cnt;
    s0 = stall_err;
    drop = 0;
    @(negedge clk);
    cfg_count = 11'(cfg);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cfg_count = 11'($urandom_range(0, 2047));
    cyc = 0;
    timed_out = 1'b1;
    while (cyc < 30000) begin
      if (done) begin
        timed_out = 1'b0;
        break;
      end
      if (!busy) drop++;
      start = (mid_start && cyc == 50) ? 1'b1 : 1'b0;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk("frame_timeout", timed_out, 0);
    chk("busy_during_frame_drops", drop, 0);
    repeat (40) @(negedge clk);
    chk("done_pulses", done_cnt - d0, 1);
    chk("busy_after_done", busy, 0);
    model(cfg);
    chk("byte_count", cap_q.size(), exp_q.size());
    mism = 0;
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
      if (cap_q[i] !== exp_q[i]) mism++;
    chk("byte_mismatches", mism, 0);
    chk("rd_en_count", addr_q.size(), n);
    mism = 0;
    for (int i = 0; i < addr_q.size(); i++)
      if (addr_q[i] != i) mism++;
    chk("rd_addr_order_errors", mism, 0);
    chk("words_sent", words_sent, n);
    chk("stall_hold_errors", stall_err - s0, 0);
  endtask

  task automatic chk_literal(input string name, input logic [7:0] exp_b[], input int len);
    int mism;
    mism = 0;
    chk({name, "_len"}, cap_q.size(), len);
    for (int i = 0; i < len && i < cap_q.size(); i++)
      if (cap_q[i] !== exp_b[i]) mism++;
    chk({name, "_bytes"}, mism, 0);
  endtask

  typedef struct {
    int cfg;
    int pct;
    int kind;
    int exp_n;
  } vec_t;

  initial begin
    vec_t       vecs[7];
    logic [7:0] lit[];
    int         cyc, d0;
    bit         timed_out;

    vecs[0] = '{cfg: 1,    pct: 100, kind: 0, exp_n: 1};
    vecs[1] = '{cfg: 0,    pct: 100, kind: 0, exp_n: 0};
    vecs[2] = '{cfg: 2,    pct: 50,  kind: 0, exp_n: 2};
    vecs[3] = '{cfg: 1024, pct: 100, kind: 1, exp_n: 1024};
    vecs[4] = '{cfg: 7,    pct: 30,  kind: 0, exp_n: 7};
    vecs[5] = '{cfg: 1025, pct: 100, kind: 0, exp_n: 1024};
    vecs[6] = '{cfg: 3,    pct: 60,  kind: 0, exp_n: 3};

    rst_n = 1'b0;
    start = 1'b0;
    cfg_count = '0;
    repeat (3) @(negedge clk);
    chk("reset_tx_valid", bus.tx_valid, 0);
    chk("reset_rd_en", bus.rd_en, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_words_sent", words_sent, 0);
    rst_n = 1'b1;

    foreach (vecs[v]) begin
      for (int i = 0; i < 1024; i++) mem[i] = (vecs[v].kind == 1) ? 32'(i) : $urandom;
      run_frame(vecs[v].cfg, vecs[v].pct, 1'b0);
      if (cap_q.size() >= 3) begin
        chk("hdr_count_lo", cap_q[1], vecs[v].exp_n % 256);
        chk("hdr_count_hi", cap_q[2], vecs[v].exp_n / 256);
      end
      if (vecs[v].kind == 1 && cap_q.size() > 0) chk("index_frame_checksum", cap_q[$], 4);
    end

    // Literal frame, one word at full ready.
    mem[0] = 32'h1122_3344;
    run_frame(1, 100, 1'b0);
    lit = '{8'hA5, 8'h01, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'hAB};
    chk_literal("lit_n1", lit, 8);

    // Two words with a stalling receiver; checksum covers both count bytes.
    mem[0] = 32'hDEAD_BEEF;
    mem[1] = 32'h0000_0001;
    run_frame(2, 50, 1'b0);
    lit = '{8'hA5, 8'h02, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h01, 8'h00, 8'h00, 8'h00, 8'h3B};
    chk_literal("lit_n2_stall", lit, 12);

    // Over-range count plus a start pulse while the frame is in flight.
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    run_frame(2000, 100, 1'b1);
    chk("clamped_frame_bytes", cap_q.size(), 4100);

    // Asynchronous reset while the fourth word is being sent.
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    ready_pct = 100;
    d0 = done_cnt;
    addr_q.delete();
    @(negedge clk);
    cfg_count = 11'd8;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    timed_out = 1'b1;
    while (cyc < 2000) begin
      if (addr_q.size() == 4 && bus.tx_valid && words_sent == 3) begin
        timed_out = 1'b0;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    chk("reach_word3_timeout", timed_out, 0);
    rst_n = 1'b0;
    #1;
    chk("midreset_tx_valid", bus.tx_valid, 0);
    chk("midreset_rd_en", bus.rd_en, 0);
    chk("midreset_busy", busy, 0);
    chk("midreset_done", done, 0);
    chk("midreset_words_sent", words_sent, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("midreset_no_done", done_cnt - d0, 0);

    mem[0] = 32'h1122_3344;
    run_frame(1, 100, 1'b0);
    lit = '{8'hA5, 8'h01, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'hAB};
    chk_literal("post_reset_n1", lit, 8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
